// File: rtl/instr_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : instr_cache_ctrl
//  Purpose  : Direct-mapped read-only instruction cache with burst line refill.
//  Revision : 1.0
// ============================================================================
module instr_cache_ctrl #(
   parameter int XLEN       = 32,
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 16
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_req,
   input  logic [XLEN-1:0] i_address,
   input  logic            i_flush,
   output logic [XLEN-1:0] o_data,
   output logic            o_done,
   output logic            o_mem_req,
   output logic [XLEN-1:0] o_mem_addr,
   input  logic            i_mem_valid,
   input  logic [XLEN-1:0] i_mem_data
);
   localparam int OFF   = $clog2(LINE_WORDS);
   localparam int IDX   = $clog2(NUM_LINES);
   localparam int TAG_W = XLEN - OFF - IDX - 2;
   localparam logic [OFF-1:0] LAST_BEAT = OFF'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOOKUP  = 2'd1,
      REFILL  = 2'd2,
      RESPOND = 2'd3
   } state_t;

   state_t state, state_next;

   logic [XLEN-1:2]      req_addr;
   logic [OFF-1:0]       beat;
   logic [NUM_LINES-1:0] valid;
   logic                 refill_flushed;
   logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
   logic [XLEN-1:0]      data_mem [NUM_LINES][LINE_WORDS];

   logic [OFF-1:0]   req_word;
   logic [IDX-1:0]   req_index;
   logic [TAG_W-1:0] req_tag;
   logic             accept, hit, miss, beat_wr, last_wr;

   // Byte-offset bits never matter for word fetches.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^i_address[1:0];

   assign req_word  = req_addr[OFF+1:2];
   assign req_index = req_addr[OFF+IDX+1:OFF+2];
   assign req_tag   = req_addr[XLEN-1:OFF+IDX+2];

   always_ff @(posedge i_clk) begin
      if (i_reset) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      hit        = 1'b0;
      miss       = 1'b0;
      beat_wr    = 1'b0;
      last_wr    = 1'b0;
      case (state)
         IDLE: begin
            // The response cycle itself is never a request-accept cycle.
            if (i_req && !o_done) begin
               accept     = 1'b1;
               state_next = LOOKUP;
            end
         end
         LOOKUP: begin
            if (valid[req_index] && (tag_mem[req_index] == req_tag) && !i_flush) begin
               hit        = 1'b1;
               state_next = IDLE;
            end else begin
               miss       = 1'b1;
               state_next = REFILL;
            end
         end
         REFILL: begin
            if (i_mem_valid) begin
               beat_wr = 1'b1;
               if (beat == LAST_BEAT) begin
                  last_wr    = 1'b1;
                  state_next = RESPOND;
               end
            end
         end
         RESPOND: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         valid          <= '0;
         o_done         <= 1'b0;
         o_data         <= '0;
         o_mem_req      <= 1'b0;
         o_mem_addr     <= '0;
         beat           <= '0;
         refill_flushed <= 1'b0;
         req_addr       <= '0;
      end else begin
         o_done <= 1'b0;
         if (accept) req_addr <= i_address[XLEN-1:2];
         if (hit) begin
            o_data <= data_mem[req_index][req_word];
            o_done <= 1'b1;
         end
         if (miss) begin
            o_mem_req      <= 1'b1;
            o_mem_addr     <= {req_addr[XLEN-1:OFF+2], {(OFF+2){1'b0}}};
            beat           <= '0;
            refill_flushed <= 1'b0;
         end
         if (beat_wr) beat <= beat + 1'b1;
         if (last_wr) o_mem_req <= 1'b0;
         if (state == RESPOND) begin
            o_data <= data_mem[req_index][req_word];
            o_done <= 1'b1;
         end
         // A flush anywhere in a refill keeps that line from becoming valid.
         if (i_flush) begin
            valid <= '0;
            if (state == REFILL) refill_flushed <= 1'b1;
         end else if (last_wr && !refill_flushed) begin
            valid[req_index] <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (beat_wr && !i_reset) data_mem[req_index][beat] <= i_mem_data;
      if (last_wr && !i_reset) tag_mem[req_index] <= req_tag;
   end

endmodule
`default_nettype wire
